// File: rtl/out_arb_pkg.sv
// rtl/out_arb_pkg.sv - shared types and bit positions for the egress arbiter network
package out_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [7:0]  channel;
    logic        sop;
    logic        eop;
    logic [63:0] data;
  } st_word_t;

  localparam int SOP_BIT = 65;
  localparam int EOP_BIT = 64;

endpackage

// File: rtl/out_arb_network_rr_pick.sv
// rtl/out_arb_network_rr_pick.sv - combinational round-robin picker
// Scans from last+1 upward (mod N) and returns the first requesting index.
module rr_pick #(
  parameter int N  = 8,
  parameter int GW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          hit,
  output logic [GW-1:0] idx
);

  // Walk the ring backwards so the nearest candidate after 'last' is written last and wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        hit = 1'b1;
        idx = GW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/out_arb_network.sv
// rtl/out_arb_network.sv - packet-aware round-robin merge of node streams into one egress stream
// Optional per-node EOP counters on pkt_count when OUT_ARB_PKTCNT_EN is defined.
module out_arb_network
  import out_arb_pkg::*;
#(
  parameter int  ncount = 8,
  localparam int GW     = (ncount > 1) ? $clog2(ncount) : 1
) (
  input  logic          clock,
  input  logic          aclr_n,
  input  logic [73:0]   req_data  [ncount],
  input  logic          req_valid [ncount],
  output logic          req_ready [ncount],
  output logic [63:0]   st_data,
  output logic          st_sop,
  output logic          st_eop,
  output logic [7:0]    st_channel,
  output logic          st_valid,
  input  logic          st_ready,
  output logic [GW-1:0] grant_idx,
  output logic          busy,
`ifdef OUT_ARB_PKTCNT_EN
  output logic [31:0]   pkt_count [ncount],
`endif
  output logic          err_orphan
);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] grant_q, grant_d;
  st_word_t      word_q, word_d;
  logic          st_valid_q, st_valid_d;
  logic          err_q, err_d;

  logic              adv;
  logic [ncount-1:0] sop_mask;
  logic              pick_hit;
  logic [GW-1:0]     pick_idx;

  always_comb begin
    adv = !st_valid_q || st_ready;
    for (int i = 0; i < ncount; i++) begin
      sop_mask[i] = req_valid[i] && req_data[i][SOP_BIT];
    end
  end

  rr_pick #(.N(ncount), .GW(GW)) u_pick (
    .req  (sop_mask),
    .last (last_q),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    word_d     = word_q;
    st_valid_d = st_valid_q && !adv;
    err_d      = 1'b0;
    for (int i = 0; i < ncount; i++) begin
      req_ready[i] = 1'b0;
    end
    case (state_q)
      IDLE: begin
        // Non-SOP words can never start a packet, so they are drained here rather than blocking the node.
        for (int i = 0; i < ncount; i++) begin
          if (req_valid[i] && !req_data[i][SOP_BIT]) begin
            req_ready[i] = 1'b1;
            err_d        = 1'b1;
          end
        end
        if (pick_hit) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_q] = adv;
        if (adv && req_valid[grant_q]) begin
          word_d     = req_data[grant_q];
          st_valid_d = 1'b1;
          if (req_data[grant_q][EOP_BIT]) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      last_q     <= GW'(ncount - 1);
      grant_q    <= '0;
      word_q     <= '0;
      st_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      word_q     <= word_d;
      st_valid_q <= st_valid_d;
      err_q      <= err_d;
    end
  end

`ifdef OUT_ARB_PKTCNT_EN
  logic [31:0] cnt_q [ncount];
  logic [31:0] cnt_d [ncount];

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == BUSY && adv && req_valid[grant_q] && req_data[grant_q][EOP_BIT]) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < ncount; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_count = cnt_q;
`endif

  assign st_data    = word_q.data;
  assign st_sop     = word_q.sop;
  assign st_eop     = word_q.eop;
  assign st_channel = word_q.channel;
  assign st_valid   = st_valid_q;
  assign grant_idx  = grant_q;
  assign busy       = (state_q == BUSY);
  assign err_orphan = err_q;

endmodule

// File: doc/out_arb_network.md
Name: out_arb_network

Overview:
- Packet-aware round-robin arbiter that merges the ncount processing-node egress streams back into one Avalon-ST egress stream.
- Sits downstream of the processing nodes fed by the ingress FIFO chain.
- Grant is held from SOP to EOP, so packets are never interleaved.
- Output is fully registered with standard valid/ready backpressure.

Parameters:
- ncount, 8, number of requesting processing nodes (2..16).
- GW, $clog2(ncount), grant index width (localparam, max(1, $clog2(ncount))).

Ports:
- clock  in  1  system clock.
- aclr_n  in  1  asynchronous active-low reset.
- req_data  in  [73:0] x ncount (unpacked)  per-node word {channel[7:0], sop, eop, data[63:0]}.
- req_valid  in  1 x ncount (unpacked)  word present.
- req_ready  out  1 x ncount (unpacked)  word accepted this cycle (transfer = valid & ready).
- st_data  out  64  egress data.
- st_sop, st_eop  out  1 each  egress packet delimiters.
- st_channel  out  8  egress channel.
- st_valid  out  1  egress word valid.
- st_ready  in  1  egress sink ready.
- grant_idx  out  GW  current or last granted node.
- busy  out  1  packet in flight.
- err_orphan  out  1  one-cycle pulse: non-SOP word discarded while IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=ncount-1, grant_idx=0, st_valid=0, st_data/st_channel/st_sop/st_eop=0, busy=0, err_orphan=0, all req_ready=0.
- adv = !st_valid | st_ready. This is the output register load enable.
- State IDLE:
  - Round-robin scan starting at last_grant+1 (mod ncount). Select the first i with req_valid[i] & req_data[i][65] (sop).
  - On a hit: grant_idx<=i, state<=BUSY next cycle. No word is consumed in IDLE, so each packet costs 1 arbitration bubble.
  - Orphan drop: every i with req_valid[i] & !sop gets req_ready[i]=1 in IDLE. The word is discarded and err_orphan pulses once per cycle in which any drop occurs.
  - Drops and a hit on a different node may coincide.
- State BUSY:
  - req_ready[grant_idx]=adv; all others 0.
  - On transfer: output register loads the word; st_valid<=1.
  - If the transferred word has eop: last_grant<=grant_idx, state<=IDLE.
  - A SOP seen mid-packet is passed through unchanged; no check is made.
- Output register:
  - If adv and no transfer, st_valid<=0.
  - st_* hold stable while st_valid & !st_ready.
- Single-word packet (sop&eop): one BUSY cycle, then IDLE.
- Latency: granted req word to st_valid is 1 cycle. Sustained throughput is 1 word/cycle within a packet.
- busy = (state==BUSY).
- grant_idx holds its value in IDLE until the next hit.
- Fairness: the node just served has lowest priority at the next scan. With N nodes continuously requesting, each is served at least once every N packets.
- Reset mid-packet: the packet is truncated; no EOP is emitted. The downstream sink tolerates this after reset.

Optional Feature:
- Macro OUT_ARB_PKTCNT_EN.
- When defined, adds output port pkt_count, 32 bits x ncount (unpacked).
  - Per-node counters increment on each EOP transfer from that node.
  - Counters wrap at 2^32 and reset to 0 on aclr_n.
- When undefined, the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package out_arb_pkg holds:
  - typedef arb_state_t {IDLE, BUSY}.
  - typedef st_word_t: packed struct {channel[7:0], sop, eop, data[63:0]} matching the 74-bit node word.
  - Bit-position constants SOP_BIT=65, EOP_BIT=64.
- One natural sub-module: rr_pick. This is a combinational round-robin priority picker with inputs req mask and last index, and outputs hit and index.

Test Plan:
- Single node 0 sends a 3-word packet (data 0x11, 0x22, 0x33; ch 0x05), st_ready=1 -> st_valid on 3 consecutive cycles starting 2 cycles after req_valid; sop on the first, eop on the third, st_channel=0x05.
- Nodes 0, 1 and 3 each present a 2-word packet at reset release -> egress order 0, 1, 3, with exactly 1 idle cycle between packets and no interleaving.
- Node 2 sends a 4-word packet; st_ready is held low for 3 cycles after the 2nd word -> st_data is held stable during the stall and req_ready[2]=0 throughout. All 4 words then emerge in order.
- Node 5 presents a non-SOP word 0xDEAD while IDLE -> it is consumed in 1 cycle, err_orphan=1 for that cycle, and nothing appears on st_valid.
- aclr_n pulsed low during the 2nd word of a 4-word packet from node 1 -> st_valid=0 immediately. After release, node 0 is scanned first and its next SOP packet is output intact.
- With OUT_ARB_PKTCNT_EN: 5 packets from node 4 and 2 from node 7 -> pkt_count[4]=5, pkt_count[7]=2, all other counters 0.
